// File: rtl/bp_pkt_arbiter_pkg.sv
// Shared types and helpers for the BytePipe packet arbiter.
package bp_pkt_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] HDR_TAG = 8'hA0;

    // Explicit modulo wrap so non-power-of-two sizes cycle correctly.
    function automatic int unsigned wrapInc(input int unsigned val, input int unsigned n);
        return (val + 1 >= n) ? 0 : val + 1;
    endfunction

endpackage

// File: rtl/bp_pkt_arbiter_rr_select.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping modulo N.
module rr_select #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            for (int j = 0; j < N; j++) begin
                if (req[j] && ((32'(ptr) + 32'(off)) % N) == 32'(j)) begin
                    any = 1'b1;
                    idx = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/bp_pkt_arbiter.sv
// Round-robin packet arbiter sharing one BytePipe stream between N_PAIR packet FIFOs.
// Define BP_PKT_ARBITER_HEADER_EN to prefix each packet with an 8'hA0|pair tag byte.
module bp_pkt_arbiter
    import bp_pkt_arbiter_pkg::*;
#(
    parameter int unsigned N_PAIR  = 2,
    parameter int unsigned PKT_LEN = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cg,
    input  logic [N_PAIR-1:0]     i_enable,
    input  logic [N_PAIR*8-1:0]   i_pktfifo_data,
    input  logic [N_PAIR-1:0]     i_pktfifo_empty,
    output logic [N_PAIR-1:0]     o_pktfifo_pop,
    output logic [7:0]            o_bp_data,
    output logic                  o_bp_valid,
    input  logic                  i_bp_ready,
    output logic [N_PAIR-1:0]     o_grant,
    output logic                  o_busy
);

    localparam int unsigned PW = (N_PAIR > 1) ? $clog2(N_PAIR) : 1;
    localparam int unsigned CW = $clog2(PKT_LEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(PKT_LEN - 1);

    state_t            stateQ, stateD;
    logic [PW-1:0]     grantQ, grantD;
    logic [PW-1:0]     ptrQ, ptrD;
    logic [PW-1:0]     selIdx;
    logic [CW-1:0]     cntQ, cntD;
    logic [N_PAIR-1:0] req;
    logic              selAny;
    logic              headEmpty;
    logic [7:0]        headByte;
    logic              accept;

    assign req = i_enable & ~i_pktfifo_empty;

    rr_select #(
        .N  (N_PAIR),
        .PW (PW)
    ) uSel (
        .req (req),
        .ptr (ptrQ),
        .idx (selIdx),
        .any (selAny)
    );

    always_comb begin
        headByte  = 8'h00;
        headEmpty = 1'b1;
        for (int i = 0; i < N_PAIR; i++) begin
            if (grantQ == PW'(i)) begin
                headByte  = i_pktfifo_data[i*8 +: 8];
                headEmpty = i_pktfifo_empty[i];
            end
        end
    end

    always_comb begin
        stateD        = stateQ;
        grantD        = grantQ;
        ptrD          = ptrQ;
        cntD          = cntQ;
        accept        = 1'b0;
        o_bp_valid    = 1'b0;
        o_bp_data     = 8'h00;
        o_pktfifo_pop = '0;
        o_busy        = (stateQ != IDLE);
        o_grant       = o_busy ? (N_PAIR'(1) << grantQ) : '0;

        unique case (stateQ)
            IDLE: begin
                if (i_cg && selAny) begin
                    grantD = selIdx;
                    cntD   = '0;
`ifdef BP_PKT_ARBITER_HEADER_EN
                    stateD = HDR;
`else
                    stateD = DATA;
`endif
                end
            end
`ifdef BP_PKT_ARBITER_HEADER_EN
            HDR: begin
                o_bp_valid = i_cg;
                o_bp_data  = HDR_TAG | 8'(grantQ);
                accept     = o_bp_valid && i_bp_ready;
                if (accept) stateD = DATA;
            end
`endif
            DATA: begin
                o_bp_valid = !headEmpty && i_cg;
                o_bp_data  = headByte;
                accept     = o_bp_valid && i_bp_ready;
                for (int i = 0; i < N_PAIR; i++) begin
                    o_pktfifo_pop[i] = accept && (grantQ == PW'(i));
                end
                // Empty head or stalled sink simply holds state and counter.
                if (accept) begin
                    if (cntQ == LAST_CNT) begin
                        stateD = IDLE;
                        ptrD   = PW'(wrapInc(32'(grantQ), N_PAIR));
                        grantD = '0;
                        cntD   = '0;
                    end else begin
                        cntD = cntQ + 1'b1;
                    end
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stateQ <= IDLE;
            grantQ <= '0;
            ptrQ   <= '0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            grantQ <= grantD;
            ptrQ   <= ptrD;
            cntQ   <= cntD;
        end
    end

endmodule

// File: tb/tb_bp_pkt_arbiter.sv
// Self-checking bench for bp_pkt_arbiter: directed scenarios plus random traffic vs a packet model.
module tb_bp_pkt_arbiter;

    localparam int N = 2;
    localparam int L = 6;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic           i_cg = 1'b1;
    logic [N-1:0]   i_enable = '1;
    logic [N*8-1:0] i_pktfifo_data = '0;
    logic [N-1:0]   i_pktfifo_empty = '1;
    logic [N-1:0]   o_pktfifo_pop;
    logic [7:0]     o_bp_data;
    logic           o_bp_valid;
    logic           i_bp_ready = 1'b1;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    int checks = 0;
    int failures = 0;

    // FIFO contents as the bench sees them; the DUT pops drain these.
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    // Packet-level model: which pair owns the stream and how many data bytes it has sent.
    bit mBusy = 0;
    bit mHdr = 0;
    int mG = 0;
    int mCnt = 0;
    int mPtr = 0;
    int popCnt0 = 0;

    bp_pkt_arbiter #(
        .N_PAIR  (N),
        .PKT_LEN (L)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_cg            (i_cg),
        .i_enable        (i_enable),
        .i_pktfifo_data  (i_pktfifo_data),
        .i_pktfifo_empty (i_pktfifo_empty),
        .o_pktfifo_pop   (o_pktfifo_pop),
        .o_bp_data       (o_bp_data),
        .o_bp_valid      (o_bp_valid),
        .i_bp_ready      (i_bp_ready),
        .o_grant         (o_grant),
        .o_busy          (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qhead(input int i);
        if (qsize(i) == 0) return 8'h00;
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic push(input int i, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            if (i == 0) q0.push_back(base + 8'(k));
            else        q1.push_back(base + 8'(k));
        end
    endtask

    task automatic modelReset();
        mBusy = 0;
        mHdr  = 0;
        mG    = 0;
        mCnt  = 0;
        mPtr  = 0;
    endtask

    // One clock cycle: drive FIFO heads, check outputs mid-cycle, clock, then advance FIFOs and model.
    task automatic step();
        logic [N-1:0] expPop;
        logic [N-1:0] expGrant;
        logic [N-1:0] popSnap;
        logic [N-1:0] req;
        logic         expValid;
        logic [7:0]   expData;
        bit           found;
        for (int i = 0; i < N; i++) begin
            i_pktfifo_empty[i]       = (qsize(i) == 0);
            i_pktfifo_data[i*8 +: 8] = qhead(i);
        end
        #1;
        expPop   = '0;
        expGrant = '0;
        expValid = 1'b0;
        expData  = 8'h00;
        if (mBusy) begin
            expGrant[mG] = 1'b1;
            if (mHdr) begin
                expValid = i_cg;
                expData  = 8'hA0 | 8'(mG);
            end else begin
                expValid   = (qsize(mG) > 0) && i_cg;
                expData    = qhead(mG);
                expPop[mG] = expValid && i_bp_ready;
            end
        end
        chk("busy", 16'(o_busy), 16'(mBusy));
        chk("grant", 16'(o_grant), 16'(expGrant));
        chk("valid", 16'(o_bp_valid), 16'(expValid));
        chk("pop", 16'(o_pktfifo_pop), 16'(expPop));
        if (expValid) chk("data", 16'(o_bp_data), 16'(expData));
        popSnap = o_pktfifo_pop;
        req     = i_enable & ~i_pktfifo_empty;
        @(posedge i_clk);
        if (popSnap[0] && q0.size() > 0) begin
            void'(q0.pop_front());
            popCnt0++;
        end
        if (popSnap[1] && q1.size() > 0) void'(q1.pop_front());
        if (i_cg) begin
            if (!mBusy) begin
                found = 0;
                for (int off = 0; off < N; off++) begin
                    if (!found && req[(mPtr + off) % N]) begin
                        found = 1;
                        mG    = (mPtr + off) % N;
                    end
                end
                if (found) begin
                    mBusy = 1;
                    mCnt  = 0;
`ifdef BP_PKT_ARBITER_HEADER_EN
                    mHdr  = 1;
`else
                    mHdr  = 0;
`endif
                end
            end else if (expValid && i_bp_ready) begin
                if (mHdr) begin
                    mHdr = 0;
                end else begin
                    mCnt++;
                    if (mCnt == L) begin
                        mBusy = 0;
                        mPtr  = (mG + 1) % N;
                    end
                end
            end
        end
        #1;
    endtask

    initial begin
        // Reset state
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("rst_valid", 16'(o_bp_valid), 16'd0);
        chk("rst_pop", 16'(o_pktfifo_pop), 16'd0);
        chk("rst_busy", 16'(o_busy), 16'd0);
        chk("rst_grant", 16'(o_grant), 16'd0);
        chk("rst_data", 16'(o_bp_data), 16'd0);
        i_rst = 1'b0;
        modelReset();

        // Single packet from FIFO0, FIFO1 empty
        push(0, 6, 8'h10);
        step();
        chk("s1_grant", 16'(o_grant), 16'b01);
        for (int t = 0; t < 10; t++) step();
        chk("s1_drained", 16'(q0.size()), 16'd0);
        chk("s1_idle", 16'(o_busy), 16'd0);

        // Both FIFOs loaded: pointer now favours FIFO1, then alternation
        push(0, 12, 8'h20);
        push(1, 12, 8'h40);
        step();
        chk("s2_first_grant", 16'(o_grant), 16'b10);
        for (int t = 0; t < 34; t++) step();
        chk("s2_q0", 16'(q0.size()), 16'd0);
        chk("s2_q1", 16'(q1.size()), 16'd0);

        // FIFO0 runs dry mid-packet while FIFO1 waits
        push(0, 3, 8'h60);
        for (int t = 0; t < 5; t++) step();
        push(1, 6, 8'h70);
        for (int t = 0; t < 3; t++) step();
        chk("s3_stall_grant", 16'(o_grant), 16'b01);
        chk("s3_q1_untouched", 16'(q1.size()), 16'd6);
        push(0, 3, 8'h63);
        for (int t = 0; t < 18; t++) step();
        chk("s3_q0", 16'(q0.size()), 16'd0);
        chk("s3_q1", 16'(q1.size()), 16'd0);

        // Sink ready pattern 1,0,0,1
        push(0, 6, 8'h80);
        popCnt0 = 0;
        for (int t = 0; t < 20; t++) begin
            i_bp_ready = (t % 4 == 0) || (t % 4 == 3);
            step();
        end
        i_bp_ready = 1'b1;
        chk("s4_pops", 16'(popCnt0), 16'd6);

        // Reset after two bytes of a packet
        for (int t = 0; t < 4; t++) step();
        push(0, 6, 8'h90);
        push(1, 6, 8'hB0);
        popCnt0 = 0;
        for (int t = 0; t < 10 && (popCnt0 < 2 || mBusy == 0); t++) step();
        chk("s5_two_bytes", 16'(popCnt0), 16'd2);
        i_rst = 1'b1;
        #1;
        chk("s5_rst_valid", 16'(o_bp_valid), 16'd0);
        chk("s5_rst_pop", 16'(o_pktfifo_pop), 16'd0);
        chk("s5_rst_busy", 16'(o_busy), 16'd0);
        chk("s5_rst_grant", 16'(o_grant), 16'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        modelReset();
        step();
        chk("s5_regrant", 16'(o_grant), 16'b01);
        push(0, 2, 8'h9E);
        for (int t = 0; t < 24; t++) step();
        chk("s5_q0", 16'(q0.size()), 16'd0);
        chk("s5_q1", 16'(q1.size()), 16'd0);

        // Random traffic, enables, clock gating and backpressure
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0 && qsize(i) < 16) push(i, 1, 8'($urandom));
                i_enable[i] = ($urandom_range(0, 4) != 0);
            end
            i_cg       = ($urandom_range(0, 9) != 0);
            i_bp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
